// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DMEM_ADDR_W = 8;
  localparam int unsigned DMEM_DATA_W = 8;
  localparam int unsigned DMEM_STAT_W = 16;
  // Holds MAX_WAIT up to 15.
  localparam int unsigned WAIT_W      = 4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner select with port-1 starvation guard and next wait_cnt value.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              req0,
  input  logic              req1,
  input  logic [WAIT_W-1:0] wait_cnt,
  output logic              any_c,
  output logic              win_c,
  output logic [WAIT_W-1:0] wait_cnt_c
);

  always_comb begin
    any_c      = req0 | req1;
    win_c      = PORT_CPU;
    wait_cnt_c = wait_cnt;

    if (req1 && (wait_cnt == WAIT_W'(MAX_WAIT))) begin
      win_c = PORT_DBG;
    end else if (req0) begin
      win_c = PORT_CPU;
    end else if (req1) begin
      win_c = PORT_DBG;
    end

    // Count port-0 wins over a pending port 1; any port-1 grant clears.
    if (any_c) begin
      if (win_c == PORT_DBG) begin
        wait_cnt_c = '0;
      end else if (req1 && (wait_cnt < WAIT_W'(MAX_WAIT))) begin
        wait_cnt_c = WAIT_W'(wait_cnt + 1'b1);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory (CPU port priority, debug port starvation guard).
// Optional grant statistics counters when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DMEM_ADDR_W,
  parameter int unsigned DATA_W   = DMEM_DATA_W,
  parameter int unsigned MAX_WAIT = 4
`ifdef DMEM_ARB_STATS_EN
  , parameter int unsigned STAT_W = DMEM_STAT_W
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  , output logic [STAT_W-1:0] stat_gnt0
  , output logic [STAT_W-1:0] stat_gnt1
  , output logic [STAT_W-1:0] stat_force
`endif
);

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                any_c;
  logic                win_c;
  logic [WAIT_W-1:0]   wait_cnt_c;

  dmem_arb_pick #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .req0       (req0),
    .req1       (req1),
    .wait_cnt   (wait_cnt_q),
    .any_c      (any_c),
    .win_c      (win_c),
    .wait_cnt_c (wait_cnt_c)
  );

  // Next state: issue the winner's command in IDLE, capture read data in ACCESS.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    wait_cnt_d  = wait_cnt_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (any_c) begin
          state_d    = ACCESS;
          sel_d      = win_c;
          wait_cnt_d = wait_cnt_c;
          if (win_c == PORT_DBG) begin
            gnt1_d      = 1'b1;
            mem_write_d = we1;
            mem_read_d  = ~we1;
            mem_addr_d  = addr1;
            mem_wdata_d = wdata1;
          end else begin
            gnt0_d      = 1'b1;
            mem_write_d = we0;
            mem_read_d  = ~we0;
            mem_addr_d  = addr0;
            mem_wdata_d = wdata0;
          end
        end
      end
      ACCESS: begin
        state_d = IDLE;
        if (mem_read_q) begin
          if (sel_q == PORT_DBG) begin
            rvalid1_d = 1'b1;
            rdata1_d  = mem_rdata;
          end else begin
            rvalid0_d = 1'b1;
            rdata0_d  = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      wait_cnt_q  <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      wait_cnt_q  <= wait_cnt_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_gnt0_q, stat_gnt0_d;
  logic [STAT_W-1:0] stat_gnt1_q, stat_gnt1_d;
  logic [STAT_W-1:0] stat_force_q, stat_force_d;
  logic              forced_c;

  // Saturating grant counters, updated when a grant is issued.
  always_comb begin
    stat_gnt0_d  = stat_gnt0_q;
    stat_gnt1_d  = stat_gnt1_q;
    stat_force_d = stat_force_q;
    forced_c     = req1 && (wait_cnt_q == WAIT_W'(MAX_WAIT));
    if ((state_q == IDLE) && any_c) begin
      if ((win_c == PORT_CPU) && (stat_gnt0_q != '1)) stat_gnt0_d = stat_gnt0_q + STAT_W'(1);
      if ((win_c == PORT_DBG) && (stat_gnt1_q != '1)) stat_gnt1_d = stat_gnt1_q + STAT_W'(1);
      if (forced_c && (stat_force_q != '1)) stat_force_d = stat_force_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_gnt0_q  <= '0;
      stat_gnt1_q  <= '0;
      stat_force_q <= '0;
    end else begin
      stat_gnt0_q  <= stat_gnt0_d;
      stat_gnt1_q  <= stat_gnt1_d;
      stat_force_q <= stat_force_d;
    end
  end

  assign stat_gnt0  = stat_gnt0_q;
  assign stat_gnt1  = stat_gnt1_q;
  assign stat_force = stat_force_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural memory, ordered grant scoreboard, scenario tasks.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       mem_read, mem_write;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_gnt0, stat_gnt1, stat_force;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_force(stat_force)
`endif
  );

  // Behavioural 256x8 memory: combinational read, write on clock edge.
  logic       mem_clr;
  logic [7:0] mem_arr [256];
  assign mem_rdata = mem_arr[mem_addr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 8'h00;
    end else if (mem_write) begin
      mem_arr[mem_addr] <= mem_wdata;
    end
  end

  typedef struct packed {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       pend;
  bit         pend_v;
  logic [7:0] ref_mem [256];
  int         n_checks = 0;
  int         n_pass   = 0;

  // Expected commands are pushed in predicted grant order; reads take data from the reference memory.
  task automatic push_exp(input logic port, input logic we, input logic [7:0] a, input logic [7:0] d);
    exp_t it;
    it.port = port; it.we = we; it.addr = a;
    if (we) begin
      ref_mem[a] = d;
      it.data = d;
    end else begin
      it.data = ref_mem[a];
    end
    exp_q.push_back(it);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_v = 1'b0;
    end else begin
      logic [7:0] rd;
      n_checks++;
      if (rvalid0 !== (pend_v && !pend.port) || rvalid1 !== (pend_v && pend.port))
        $display("FAIL rvalid: got rvalid0=%b rvalid1=%b, want pending=%b port=%b", rvalid0, rvalid1, pend_v, pend.port);
      else n_pass++;
      if (pend_v) begin
        rd = pend.port ? rdata1 : rdata0;
        n_checks++;
        if (rd !== pend.data)
          $display("FAIL rdata%0d: got %h, want %h (addr %h)", pend.port, rd, pend.data, pend.addr);
        else n_pass++;
      end
      pend_v = 1'b0;
      if (gnt0 || gnt1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL grant: unexpected gnt0=%b gnt1=%b, want none", gnt0, gnt1);
        end else begin
          exp_t it;
          it = exp_q.pop_front();
          if (gnt0 !== !it.port || gnt1 !== it.port || mem_read !== !it.we || mem_write !== it.we ||
              mem_addr !== it.addr || (it.we && mem_wdata !== it.data))
            $display("FAIL grant: got g0=%b g1=%b rd=%b wr=%b a=%h wd=%h, want port=%b we=%b a=%h d=%h",
                     gnt0, gnt1, mem_read, mem_write, mem_addr, mem_wdata, it.port, it.we, it.addr, it.data);
          else n_pass++;
          if (!it.we) begin
            pend   = it;
            pend_v = 1'b1;
          end
        end
      end else begin
        n_checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0)
          $display("FAIL idle_cmd: got mem_read=%b mem_write=%b, want 0 0", mem_read, mem_write);
        else n_pass++;
      end
    end
  end

  // Present one command on a port and hold it until granted; lat = edges waited.
  task automatic issue(input logic port, input logic we, input logic [7:0] a, input logic [7:0] d,
                       output int lat);
    if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    lat = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if ((port ? gnt1 : gnt0) === 1'b1) break;
      if (lat >= 64) begin
        n_checks++;
        $display("FAIL timeout: port %0d not granted after %0d cycles, want a grant", port, lat);
        break;
      end
    end
    if (port) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80 && (exp_q.size() != 0 || pend_v); i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    #1;
    n_checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write} !== 6'b0 ||
        rdata0 !== 8'h00 || rdata1 !== 8'h00 || mem_addr !== 8'h00 || mem_wdata !== 8'h00)
      $display("FAIL reset: got g=%b%b v=%b%b rd=%b wr=%b r0=%h r1=%h a=%h wd=%h, want all 0",
               gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write, rdata0, rdata1, mem_addr, mem_wdata);
    else n_pass++;
    n_checks++;
    if (dut.wait_cnt_q !== 4'd0) $display("FAIL reset_wait_cnt: got %0d, want 0", dut.wait_cnt_q);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_basic();
    int lat;
    repeat (2) @(posedge clk); #1;
    push_exp(1'b0, 1'b1, 8'h10, 8'h5A);
    push_exp(1'b0, 1'b0, 8'h10, 8'h00);
    issue(1'b0, 1'b1, 8'h10, 8'h5A, lat);
    n_checks++;
    if (lat !== 1) $display("FAIL write_latency: got %0d, want 1", lat); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (rvalid0 !== 1'b0) $display("FAIL write_rvalid: got %b, want 0", rvalid0); else n_pass++;
    issue(1'b0, 1'b0, 8'h10, 8'h00, lat);
    n_checks++;
    if (lat !== 1) $display("FAIL read_latency: got %0d, want 1", lat); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'h5A)
      $display("FAIL read_resp: got rvalid0=%b rdata0=%h, want 1 5a", rvalid0, rdata0);
    else n_pass++;
    wait_drain();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL basic_drain: got %0d left, want 0", exp_q.size()); else n_pass++;
  endtask

  // Both ports request continuously: four port-0 grants, then one forced port-1 grant.
  task automatic run_contention();
    repeat (2) @(posedge clk); #1;
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) push_exp(1'b0, 1'b0, 8'h01, 8'h00);
      push_exp(1'b1, 1'b0, 8'h02, 8'h00);
    end
    fork
      begin
        int lat0;
        for (int k = 0; k < 16; k++) issue(1'b0, 1'b0, 8'h01, 8'h00, lat0);
      end
      begin
        int lat1;
        for (int k = 0; k < 4; k++) issue(1'b1, 1'b0, 8'h02, 8'h00, lat1);
      end
    join
    wait_drain();
  endtask

  task automatic test_priority();
    run_contention();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL priority_drain: got %0d left, want 0", exp_q.size()); else n_pass++;
    n_checks++;
    if (dut.wait_cnt_q !== 4'd0) $display("FAIL wait_cnt_clear: got %0d, want 0", dut.wait_cnt_q);
    else n_pass++;
  endtask

  task automatic test_raw_cross_port();
    int lat;
    repeat (2) @(posedge clk); #1;
    push_exp(1'b0, 1'b0, 8'h20, 8'h00);
    push_exp(1'b1, 1'b1, 8'h20, 8'hC3);
    push_exp(1'b0, 1'b0, 8'h20, 8'h00);
    fork
      begin int l0; issue(1'b0, 1'b0, 8'h20, 8'h00, l0); end
      begin int l1; issue(1'b1, 1'b1, 8'h20, 8'hC3, l1); end
    join
    issue(1'b0, 1'b0, 8'h20, 8'h00, lat);
    @(posedge clk); #1;
    n_checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'hC3)
      $display("FAIL raw_read: got rvalid0=%b rdata0=%h, want 1 c3", rvalid0, rdata0);
    else n_pass++;
    wait_drain();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL raw_drain: got %0d left, want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    int lat;
    repeat (2) @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h30; wdata0 = 8'hFF;
    @(posedge clk); #1;
    n_checks++;
    if (gnt0 !== 1'b1 || mem_write !== 1'b1)
      $display("FAIL mid_access: got gnt0=%b mem_write=%b, want 1 1", gnt0, mem_write);
    else n_pass++;
    #1;
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0;
    #1;
    n_checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write} !== 6'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00)
      $display("FAIL async_reset: got g=%b%b v=%b%b rd=%b wr=%b a=%h wd=%h, want all 0",
               gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write, mem_addr, mem_wdata);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    n_checks++;
    if (mem_arr[8'h30] !== 8'h00) $display("FAIL dropped_write: got mem[30]=%h, want 00", mem_arr[8'h30]);
    else n_pass++;
    @(posedge clk); #1;
    push_exp(1'b0, 1'b0, 8'h30, 8'h00);
    issue(1'b0, 1'b0, 8'h30, 8'h00, lat);
    wait_drain();
    n_checks++;
    if (rdata0 !== 8'h00) $display("FAIL post_reset_read: got %h, want 00", rdata0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int  n_gnt;
    int  w;
    bit  prev;
    repeat (2) @(posedge clk); #1;
    for (int k = 0; k < 6; k++) push_exp(1'b1, 1'b0, 8'h02, 8'h00);
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02; wdata1 = 8'h00;
    n_gnt = 0;
    prev  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (gnt1 && prev) $display("FAIL consecutive_gnt: got gnt1 on cycles %0d and %0d, want gap", c - 1, c);
      else n_pass++;
      n_checks++;
      if (mem_read !== gnt1) $display("FAIL read_window: got mem_read=%b gnt1=%b, want equal", mem_read, gnt1);
      else n_pass++;
      if (gnt1) n_gnt++;
      prev = gnt1;
    end
    n_checks++;
    if (n_gnt != 5) $display("FAIL gnt_rate: got %0d grants in 10 cycles, want 5", n_gnt); else n_pass++;
    w = 0;
    while (gnt1 !== 1'b1 && w < 8) begin @(posedge clk); #1; w++; end
    req1 = 1'b0;
    wait_drain();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL b2b_drain: got %0d left, want 0", exp_q.size()); else n_pass++;
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    test_reset();
    run_contention();
    n_checks++;
    if (stat_gnt0 !== 16'd16 || stat_gnt1 !== 16'd4 || stat_force !== 16'd4)
      $display("FAIL stats: got gnt0=%0d gnt1=%0d force=%0d, want 16 4 4", stat_gnt0, stat_gnt1, stat_force);
    else n_pass++;
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    mem_clr = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    @(posedge clk);
    @(negedge clk) mem_clr = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_raw_cross_port();
    test_reset_mid_access();
    test_back_to_back();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
